note_scheduler: RTL and testbench

Time-shares the single square-wave tone generator among the eight piano key enables (C, D, E, F, G, A, B, C2). The block sits between the switch-to-enable mapping and the tone generator. It synchronizes and optionally debounces the eight enables, then selects one active note at a time. When several keys are held, it cycles through them round-robin with a fixed dwell time, producing an arpeggiated chord. For the selected note it drives the note index and the half-period count for the tone generator.

---
 rtl/note_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_note_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// note_scheduler: shares one square-wave tone generator among eight piano
// key enables (C D E F G A B C2). Keys are synchronized, optionally debounced,
// and held keys are played one at a time in ascending round-robin order with
// a fixed dwell per note (arpeggiated chord).
//
// Build option: define NOTE_SCHED_DEBOUNCE_EN to add a per-key debounce filter
// of DB_CYCLES stable cycles; otherwise keys follow the synchronizer directly.
module note_scheduler #(
  parameter int DWELL     = 2500000,
  parameter int DB_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en,
  output logic        note_on,
  output logic [2:0]  note_idx,
  output logic [17:0] half_period,
  output logic        note_change
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  // Elaboration-time guard on parameter ranges.
  if (DWELL < 2 || DB_CYCLES < 1) begin : g_bad_param
    $error("note_scheduler: DWELL must be >= 2 and DB_CYCLES >= 1");
  end

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  logic [7:0]    r_sync1, r_sync2;
  logic [7:0]    w_keys;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic          r_note_on, r_chg, w_chg_nxt;
  logic [17:0]   r_half;
  logic [2:0]    w_next, w_lowest;

  // Two-flop synchronizer; en is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= en;
      r_sync2 <= r_sync1;
    end
  end

`ifdef NOTE_SCHED_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);

  logic [7:0]         r_keys;
  logic [7:0][DW-1:0] r_db_cnt;

  // Per-key filter: a key flips only after the synchronized input has
  // disagreed with it for DB_CYCLES cycles in a row; any agreeing cycle
  // restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keys   <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_sync2[i] == r_keys[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          r_keys[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_keys = r_keys;
`else
  assign w_keys = r_sync2;
`endif

  // Next held key strictly above cur, wrapping 7->0; returns cur if none.
  function automatic logic [2:0] f_next_above(input logic [7:0] k,
                                              input logic [2:0] cur);
    logic [2:0] r, j;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int s = 1; s < 8; s++) begin
      j = cur + 3'(s);
      if (!found && k[j]) begin
        r     = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Lowest held key (0 if none held; caller qualifies with |k).
  function automatic logic [2:0] f_lowest(input logic [7:0] k);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (k[i]) r = 3'(i);
    return r;
  endfunction

  // Half-period counts for a 50 MHz clock.
  function automatic logic [17:0] f_half(input logic [2:0] idx);
    logic [17:0] r;
    case (idx)
      3'd0:    r = 18'd95556;
      3'd1:    r = 18'd85131;
      3'd2:    r = 18'd75843;
      3'd3:    r = 18'd71586;
      3'd4:    r = 18'd63776;
      3'd5:    r = 18'd56818;
      3'd6:    r = 18'd50619;
      default: r = 18'd47778;
    endcase
    return r;
  endfunction

  assign w_next   = f_next_above(w_keys, r_idx);
  assign w_lowest = f_lowest(w_keys);

  // Scheduler state, dwell counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_note_on <= 1'b0;
      r_chg     <= 1'b0;
      r_half    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_note_on <= (w_state_nxt == S_PLAY);
      r_chg     <= w_chg_nxt;
      r_half    <= (w_state_nxt == S_PLAY) ? f_half(w_idx_nxt) : 18'd0;
    end
  end

  // Next-state logic: all-off beats current-key release beats dwell expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_chg_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_keys) begin
          w_state_nxt = S_PLAY;
          w_idx_nxt   = w_lowest;
          w_cnt_nxt   = CW'(DWELL - 1);
          w_chg_nxt   = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_keys == 8'h00) begin
          // note_idx keeps its last value while idle
          w_state_nxt = S_IDLE;
        end else if (!w_keys[r_idx]) begin
          w_idx_nxt = w_next;
          w_cnt_nxt = CW'(DWELL - 1);
          w_chg_nxt = 1'b1;
        end else if (r_cnt == '0) begin
          // solo key simply restarts its dwell with no pulse
          w_cnt_nxt = CW'(DWELL - 1);
          if (w_next != r_idx) begin
            w_idx_nxt = w_next;
            w_chg_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign note_on     = r_note_on;
  assign note_idx    = r_idx;
  assign half_period = r_half;
  assign note_change = r_chg;

endmodule

// File: tb/tb_note_scheduler.sv
module tb_note_scheduler;
  localparam int DWELL = 4;
  localparam int DB    = 3;

  typedef struct packed {
    logic        on;
    logic [2:0]  idx;
    logic [17:0] hp;
    logic        chg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en = 8'h10;
  logic        note_on, note_change;
  logic [2:0]  note_idx;
  logic [17:0] half_period;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   done   = 0;
  exp_t sb[$];
  logic [7:0] hist[$];

  bit   m_on;
  int   m_idx, m_rem;
  logic [7:0] m_keys;
  int   m_db[8];
  int   HP[8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  note_scheduler #(.DWELL(DWELL), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .note_on(note_on),
    .note_idx(note_idx), .half_period(half_period), .note_change(note_change)
  );

  always #5 clk = ~clk;

  function automatic int next_above(input logic [7:0] k, input int cur);
    for (int s = 1; s <= 8; s++)
      if (k[(cur + s) % 8]) return (cur + s) % 8;
    return cur;
  endfunction

  function automatic int lowest(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return 0;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  task automatic model_reset(input logic [7:0] v);
    m_on = 0; m_idx = 0; m_rem = 0; m_keys = '0;
    for (int i = 0; i < 8; i++) m_db[i] = 0;
    hist.delete();
    hist.push_back(8'h00); hist.push_back(8'h00); hist.push_back(v);
  endtask

  function automatic exp_t model_edge();
    logic [7:0] s, k;
    bit nc;
    exp_t e;
    s = hist[hist.size() - 3];
`ifdef NOTE_SCHED_DEBOUNCE_EN
    k = m_keys;
    for (int i = 0; i < 8; i++) begin
      if (s[i] == m_keys[i]) m_db[i] = 0;
      else if (++m_db[i] == DB) begin m_keys[i] = s[i]; m_db[i] = 0; end
    end
`else
    k = s;
`endif
    nc = 0;
    if (!m_on) begin
      if (k != 0) begin m_on = 1; m_idx = lowest(k); m_rem = DWELL; nc = 1; end
    end else if (k == 0) begin
      m_on = 0;
    end else if (!k[m_idx]) begin
      m_idx = next_above(k, m_idx); m_rem = DWELL; nc = 1;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_rem = DWELL;
        if (next_above(k, m_idx) != m_idx) begin
          m_idx = next_above(k, m_idx); nc = 1;
        end
      end
    end
    e.on  = m_on;
    e.idx = 3'(m_idx);
    e.hp  = m_on ? 18'(HP[m_idx]) : 18'd0;
    e.chg = nc;
    return e;
  endfunction

  task automatic step(input logic [7:0] v);
    exp_t e;
    @(posedge clk);
    e = model_edge();
    #1;
    en = v;
    hist.push_back(v);
    sb.push_back(e);
  endtask

  task automatic seg(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic rst_pulse(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b0; en = v;
      #1;
      checks++;
      if ({note_on, note_idx, half_period, note_change} !== '0) begin
        errors++;
        $display("FAIL reset@cyc%0d: outputs not 0 during reset (on=%0b idx=%0d hp=%0d chg=%0b)",
                 cyc, note_on, note_idx, half_period, note_change);
      end
      sb.push_back(zero_exp());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset(v);
    sb.push_back(zero_exp());
  endtask

  initial begin
    #1000000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {note_on, note_idx, half_period, note_change};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out@cyc%0d: got on=%0b idx=%0d hp=%0d chg=%0b, want on=%0b idx=%0d hp=%0d chg=%0b",
                   cyc, a.on, a.idx, a.hp, a.chg, e.on, e.idx, e.hp, e.chg);
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    int mode, n;
    model_reset(8'h10);
    v = 8'h10;
    rst_pulse(3, 8'h10);
    seg(8'h10, 8);
    seg(8'h00, 5);
    seg(8'h85, 14);
    seg(8'h00, 5);
    seg(8'h85, 6);
    seg(8'h81, 10);
    seg(8'h01, 20);
    seg(8'h00, 6);
    seg(8'h08, 2);
    seg(8'h00, 6);
    seg(8'h08, 10);
    seg(8'h00, 4);
    seg(8'h85, 7);
    rst_pulse(2, 8'h85);
    seg(8'h85, 12);
    for (int s = 0; s < 70; s++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: v = 8'h00;
        1: v = 8'h01 << $urandom_range(0, 7);
        2: v = 8'($urandom);
        default: v = v ^ (8'h01 << $urandom_range(0, 7));
      endcase
      n = $urandom_range(1, 14);
      if ($urandom_range(0, 19) == 0) rst_pulse($urandom_range(1, 3), v);
      else seg(v, n);
    end
    seg(8'h00, 8);
    @(negedge clk); #1;
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
